// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_stage_if #(
  parameter int ADDR_W = 10
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM latch, data-memory access FSM with timeout,
// MEM/WB latch and branch resolution.
//   state    | meaning
//   S_IDLE   | no access in flight; a latched memory op is checked and launched
//   S_ACCESS | request asserted, waiting for dmem_ack (bounded by TIMEOUT)
//   S_ERROR  | timeout or misaligned access; sticky until reset
module mem_access_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_in_valid,
  input  logic [31:0]         i_alu_out,
  input  logic [31:0]         i_data_write,
  input  logic [4:0]          i_wb_register,
  input  logic                i_zero,
  input  logic [2:0]          i_mem_control,
  input  logic [1:0]          i_wb_control,
  output logic                o_stall,
  output logic                o_pc_src,
  output logic                o_wbo_valid,
  output logic                o_wbo_reg_write,
  output logic                o_wbo_mem_to_reg,
  output logic [31:0]         o_wbo_rdata,
  output logic [31:0]         o_wbo_alu_out,
  output logic [4:0]          o_wbo_register,
  output logic                o_mem_error,
  mem_access_stage_if.master  dmem
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERROR} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;

  logic        r_ex_valid;
  logic [31:0] r_alu_out;
  logic [31:0] r_wdata;
  logic [4:0]  r_register;
  logic        r_zero;
  logic [2:0]  r_mem_ctl;
  logic [1:0]  r_wb_ctl;

  logic        r_wbo_valid;
  logic        r_wbo_reg_write;
  logic        r_wbo_mem_to_reg;
  logic [31:0] r_wbo_rdata;
  logic [31:0] r_wbo_alu_out;
  logic [4:0]  r_wbo_register;

  logic w_mem_op;
  logic w_is_write;
  logic w_misalign;
  logic w_stall;
  logic w_req;
  logic w_complete;

  // Read and write both set behaves as a write.
  assign w_mem_op   = r_ex_valid & (r_mem_ctl[0] | r_mem_ctl[1]);
  assign w_is_write = r_mem_ctl[1];
  assign w_misalign = |r_alu_out[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_req      = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          w_stall = 1'b1;
          w_next  = w_misalign ? S_ERROR : S_ACCESS;
        end else begin
          w_complete = r_ex_valid;
        end
      end
      S_ACCESS: begin
        w_req = 1'b1;
        if (dmem.dmem_ack) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == C_LAST) begin
            w_next = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        w_stall = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_ACCESS && !dmem.dmem_ack) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_alu_out  <= '0;
      r_wdata    <= '0;
      r_register <= '0;
      r_zero     <= 1'b0;
      r_mem_ctl  <= '0;
      r_wb_ctl   <= '0;
    end else if (!w_stall) begin
      r_ex_valid <= i_in_valid;
      r_alu_out  <= i_alu_out;
      r_wdata    <= i_data_write;
      r_register <= i_wb_register;
      r_zero     <= i_zero;
      r_mem_ctl  <= i_in_valid ? i_mem_control : 3'b000;
      r_wb_ctl   <= i_in_valid ? i_wb_control  : 2'b00;
    end
  end

  // Anything that does not complete this edge leaves a cleared bubble behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbo_valid      <= 1'b0;
      r_wbo_reg_write  <= 1'b0;
      r_wbo_mem_to_reg <= 1'b0;
      r_wbo_rdata      <= '0;
      r_wbo_alu_out    <= '0;
      r_wbo_register   <= '0;
    end else if (w_complete) begin
      r_wbo_valid      <= 1'b1;
      r_wbo_reg_write  <= r_wb_ctl[0] & ~w_is_write;
      r_wbo_mem_to_reg <= r_wb_ctl[1];
      r_wbo_rdata      <= (r_state == S_ACCESS && !w_is_write) ? dmem.dmem_rdata : 32'h0;
      r_wbo_alu_out    <= r_alu_out;
      r_wbo_register   <= r_register;
    end else begin
      r_wbo_valid      <= 1'b0;
      r_wbo_reg_write  <= 1'b0;
      r_wbo_mem_to_reg <= 1'b0;
      r_wbo_rdata      <= '0;
      r_wbo_alu_out    <= '0;
      r_wbo_register   <= '0;
    end
  end

  assign o_stall          = w_stall;
  assign o_pc_src         = r_ex_valid & r_mem_ctl[2] & r_zero;
  assign o_mem_error      = (r_state == S_ERROR);
  assign o_wbo_valid      = r_wbo_valid;
  assign o_wbo_reg_write  = r_wbo_reg_write & r_wbo_valid;
  assign o_wbo_mem_to_reg = r_wbo_mem_to_reg;
  assign o_wbo_rdata      = r_wbo_rdata;
  assign o_wbo_alu_out    = r_wbo_alu_out;
  assign o_wbo_register   = r_wbo_register;

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_req & w_is_write;
  assign dmem.dmem_addr  = r_alu_out[ADDR_W+1:2];
  assign dmem.dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle ops,
// hand-written sequences for loads, stores, timeout, misalignment and reset.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic [31:0] i_alu_out;
  logic [31:0] i_data_write;
  logic [4:0]  i_wb_register;
  logic        i_zero;
  logic [2:0]  i_mem_control;
  logic [1:0]  i_wb_control;
  logic        o_stall;
  logic        o_pc_src;
  logic        o_wbo_valid;
  logic        o_wbo_reg_write;
  logic        o_wbo_mem_to_reg;
  logic [31:0] o_wbo_rdata;
  logic [31:0] o_wbo_alu_out;
  logic [4:0]  o_wbo_register;
  logic        o_mem_error;

  int n_chk;
  int n_fail;

  mem_access_stage_if #(.ADDR_W(10)) m ();

  mem_access_stage #(.ADDR_W(10), .TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_in_valid       (i_in_valid),
    .i_alu_out        (i_alu_out),
    .i_data_write     (i_data_write),
    .i_wb_register    (i_wb_register),
    .i_zero           (i_zero),
    .i_mem_control    (i_mem_control),
    .i_wb_control     (i_wb_control),
    .o_stall          (o_stall),
    .o_pc_src         (o_pc_src),
    .o_wbo_valid      (o_wbo_valid),
    .o_wbo_reg_write  (o_wbo_reg_write),
    .o_wbo_mem_to_reg (o_wbo_mem_to_reg),
    .o_wbo_rdata      (o_wbo_rdata),
    .o_wbo_alu_out    (o_wbo_alu_out),
    .o_wbo_register   (o_wbo_register),
    .o_mem_error      (o_mem_error),
    .dmem             (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] alu;
    logic [4:0]  rg;
    logic        zero;
    logic [2:0]  mc;
    logic [1:0]  wc;
    logic        stray_ack;
    logic        e_pc;
    logic        e_wv;
    logic        e_rw;
    logic        e_m2r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rg, input logic zero, input logic [2:0] mc,
                       input logic [1:0] wc);
    i_in_valid    = vld;
    i_alu_out     = alu;
    i_data_write  = wd;
    i_wb_register = rg;
    i_zero        = zero;
    i_mem_control = mc;
    i_wb_control  = wc;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 2'b00);
  endtask

  // Called at the sample point after the capture edge; acks on the ack_at-th request cycle.
  task automatic run_access(input int ack_at, input int ncyc, input logic [31:0] rdata,
                            input logic [9:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
                            output int reqc, output int stallc, output int bad, output bit done);
    reqc = 0; stallc = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < ncyc && !done; c++) begin
      if (m.dmem_req) begin
        reqc++;
        if (m.dmem_addr !== e_addr || m.dmem_we !== e_we || m.dmem_wdata !== e_wdata) bad++;
        if (reqc == ack_at) begin
          m.dmem_ack   = 1'b1;
          m.dmem_rdata = rdata;
        end
      end
      #1;
      if (o_stall) stallc++;
      if (m.dmem_ack) done = 1'b1;
      @(posedge clk);
      #1;
      m.dmem_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int  reqc, stallc, bad;
  bit  done;

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{1'b1, 32'h0000_0005, 5'd3,  1'b0, 3'b000, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0010, 5'd0,  1'b1, 3'b100, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0010, 5'd0,  1'b0, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0007, 5'd9,  1'b1, 3'b100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 5'd31, 1'b1, 3'b000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0020, 5'd12, 1'b0, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    bubble();
    m.dmem_ack   = 1'b0;
    m.dmem_rdata = 32'h0;
    #2;
    chk("rst_stall",     32'(o_stall),     32'h0);
    chk("rst_req",       32'(m.dmem_req),  32'h0);
    chk("rst_wbo_valid", 32'(o_wbo_valid), 32'h0);
    chk("rst_mem_error", 32'(o_mem_error), 32'h0);
    chk("rst_pc_src",    32'(o_pc_src),    32'h0);
    chk("rst_wbo_rdata", o_wbo_rdata,      32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].vld, vecs[i].alu, 32'h0, vecs[i].rg, vecs[i].zero, vecs[i].mc, vecs[i].wc);
      if (vecs[i].stray_ack) begin
        m.dmem_ack   = 1'b1;
        m.dmem_rdata = 32'hFFFF_0000;
      end
      tick();
      chk($sformatf("v%0d_pc_src", i), 32'(o_pc_src),    32'(vecs[i].e_pc));
      chk($sformatf("v%0d_stall", i),  32'(o_stall),     32'h0);
      chk($sformatf("v%0d_err", i),    32'(o_mem_error), 32'h0);
      bubble();
      tick();
      m.dmem_ack = 1'b0;
      chk($sformatf("v%0d_wbo_valid", i), 32'(o_wbo_valid),     32'(vecs[i].e_wv));
      chk($sformatf("v%0d_reg_write", i), 32'(o_wbo_reg_write), 32'(vecs[i].e_rw));
      if (vecs[i].e_wv) begin
        chk($sformatf("v%0d_m2r", i),      32'(o_wbo_mem_to_reg), 32'(vecs[i].e_m2r));
        chk($sformatf("v%0d_alu_out", i),  o_wbo_alu_out,         vecs[i].alu);
        chk($sformatf("v%0d_register", i), 32'(o_wbo_register),   32'(vecs[i].rg));
      end
    end
    tick();
    chk("bubble_wbo_valid", 32'(o_wbo_valid), 32'h0);

    // Load at 0x40, ack on third request cycle.
    drive(1'b1, 32'h0000_0040, 32'h0, 5'd7, 1'b0, 3'b001, 2'b11);
    tick();
    bubble();
    run_access(3, 12, 32'hDEAD_BEEF, 10'h010, 1'b0, 32'h0, reqc, stallc, bad, done);
    chk("lw_done",     32'(done),   32'h1);
    chk("lw_req_cyc",  32'(reqc),   32'd3);
    chk("lw_stall_cyc",32'(stallc), 32'd3);
    chk("lw_bus",      32'(bad),    32'd0);
    chk("lw_wbo_valid",32'(o_wbo_valid),      32'h1);
    chk("lw_rdata",    o_wbo_rdata,           32'hDEAD_BEEF);
    chk("lw_m2r",      32'(o_wbo_mem_to_reg), 32'h1);
    chk("lw_rw",       32'(o_wbo_reg_write),  32'h1);
    chk("lw_reg",      32'(o_wbo_register),   32'd7);
    chk("lw_req_off",  32'(m.dmem_req),       32'h0);
    chk("lw_stall_off",32'(o_stall),          32'h0);
    tick();
    chk("lw_after_valid", 32'(o_wbo_valid), 32'h0);

    // Store at 0x44, acked in the first request cycle.
    drive(1'b1, 32'h0000_0044, 32'h0000_1234, 5'd5, 1'b0, 3'b010, 2'b00);
    tick();
    bubble();
    run_access(1, 12, 32'h0, 10'h011, 1'b1, 32'h0000_1234, reqc, stallc, bad, done);
    chk("sw_done",      32'(done),   32'h1);
    chk("sw_req_cyc",   32'(reqc),   32'd1);
    chk("sw_stall_cyc", 32'(stallc), 32'd1);
    chk("sw_bus",       32'(bad),    32'd0);
    chk("sw_wbo_valid", 32'(o_wbo_valid),     32'h1);
    chk("sw_rw",        32'(o_wbo_reg_write), 32'h0);
    tick();

    // Timeout: ack never arrives.
    drive(1'b1, 32'h0000_0080, 32'h0, 5'd2, 1'b0, 3'b001, 2'b11);
    tick();
    bubble();
    run_access(0, 12, 32'h0, 10'h020, 1'b0, 32'h0, reqc, stallc, bad, done);
    chk("to_done",      32'(done),        32'h0);
    chk("to_req_cyc",   32'(reqc),        32'd4);
    chk("to_stall_cyc", 32'(stallc),      32'd12);
    chk("to_bus",       32'(bad),         32'd0);
    chk("to_mem_error", 32'(o_mem_error), 32'h1);
    chk("to_req",       32'(m.dmem_req),  32'h0);
    chk("to_stall",     32'(o_stall),     32'h1);
    rst_n = 1'b0;
    #1;
    chk("to_rst_error", 32'(o_mem_error), 32'h0);
    chk("to_rst_req",   32'(m.dmem_req),  32'h0);
    chk("to_rst_stall", 32'(o_stall),     32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Misaligned load at 0x42.
    drive(1'b1, 32'h0000_0042, 32'h0, 5'd4, 1'b0, 3'b001, 2'b11);
    tick();
    bubble();
    run_access(1, 6, 32'h0, 10'h010, 1'b0, 32'h0, reqc, stallc, bad, done);
    chk("mis_req_cyc",   32'(reqc),        32'd0);
    chk("mis_done",      32'(done),        32'h0);
    chk("mis_mem_error", 32'(o_mem_error), 32'h1);
    chk("mis_stall",     32'(o_stall),     32'h1);
    do_reset();
    chk("mis_rst_error", 32'(o_mem_error), 32'h0);

    // Reset while a load is pending.
    drive(1'b1, 32'h0000_0040, 32'h0, 5'd7, 1'b0, 3'b001, 2'b11);
    tick();
    bubble();
    tick();
    chk("pend_req", 32'(m.dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("pend_rst_req",   32'(m.dmem_req),  32'h0);
    chk("pend_rst_valid", 32'(o_wbo_valid), 32'h0);
    chk("pend_rst_stall", 32'(o_stall),     32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
